// File: rtl/pinball_pkg.sv
// Shared types and default constants for the pinball ball-serve logic.
package pinball_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READY,
      PLAY,
      LOST,
      OVER
   } serve_state_t;

   localparam int LIFE_W                 = 4;
   localparam int DEF_INIT_LIFE          = 3;
   localparam int DEF_MAX_LIFE           = 9;
   localparam int DEF_RESPAWN_FRAMES     = 60;
   localparam int DEF_AUTO_LAUNCH_FRAMES = 300;

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-tick counter: clear beats load beats count; terminal flags a match
// against the caller-supplied terminal value.
module frame_timer #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         resetN,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] loadValue,
   input  logic         countUp,
   input  logic         countDown,
   input  logic [W-1:0] termValue,
   output logic         terminal
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (load)
         count_d = loadValue;
      else if (countUp)
         count_d = count_q + W'(1);
      else if (countDown && (count_q != '0))
         count_d = count_q - W'(1);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign terminal = (count_q == termValue);

endmodule

// File: rtl/ball_serve_controller.sv
// Ball life-cycle sequencer: serve, launch, play, respawn and game over.
// Optional bonus lives are enabled with `define BONUS_LIFE_EN.
module ball_serve_controller
   import pinball_pkg::*;
#(
   parameter int INIT_LIFE          = DEF_INIT_LIFE,
   parameter int MAX_LIFE           = DEF_MAX_LIFE,
   parameter int RESPAWN_FRAMES     = DEF_RESPAWN_FRAMES,
   parameter int AUTO_LAUNCH_FRAMES = DEF_AUTO_LAUNCH_FRAMES
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              start,
   input  logic              startOfFrame,
   input  logic              launchKeyIsPressed,
   input  logic              ballLost,
   input  logic              scoreMilestone,
   output logic [LIFE_W-1:0] life,
   output logic              ballVisible,
   output logic              ballOnPlunger,
   output logic              launchPulse,
   output logic              respawnActive
);

   localparam int CNT_W = $clog2(maxInt(RESPAWN_FRAMES, AUTO_LAUNCH_FRAMES) + 1);
   localparam logic [CNT_W-1:0]  AUTO_TERM = CNT_W'(AUTO_LAUNCH_FRAMES - 1);
   localparam logic [CNT_W-1:0]  RESP_LOAD = CNT_W'(RESPAWN_FRAMES);
   localparam logic [CNT_W-1:0]  RESP_TERM = CNT_W'(1);
   localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(INIT_LIFE);
   localparam logic [LIFE_W-1:0] LIFE_CEIL = LIFE_W'(MAX_LIFE);

   serve_state_t      state_q, state_d;
   logic [LIFE_W-1:0] life_q, life_d, lifeBonus, lifeLess;
   logic              visible_q, plunger_q, launch_q, respawn_q;
   logic              keyArmed_q, keyArmed_d;
   logic              launching, milestone, timerTerminal;
   logic              timerClear, timerLoad, timerUp, timerDown;

`ifdef BONUS_LIFE_EN
   assign milestone = scoreMilestone;
   assign lifeBonus = (scoreMilestone && (life_q < LIFE_CEIL)) ? life_q + LIFE_W'(1) : life_q;
`else
   logic unusedBonus;
   assign unusedBonus = &{scoreMilestone, LIFE_CEIL};
   assign milestone   = 1'b0;
   assign lifeBonus   = life_q;
`endif

   assign lifeLess = (life_q == '0) ? '0 : life_q - LIFE_W'(1);

   // Next-state and life decode; start low wins over everything else.
   always_comb begin
      state_d   = state_q;
      life_d    = life_q;
      launching = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = READY;
         READY: begin
            life_d = lifeBonus;
            if ((launchKeyIsPressed && keyArmed_q) || (startOfFrame && timerTerminal)) begin
               state_d   = PLAY;
               launching = 1'b1;
            end
         end
         PLAY: begin
            if (ballLost && !milestone) begin
               life_d  = lifeLess;
               state_d = (lifeLess != '0) ? LOST : OVER;
            end else if (!ballLost) begin
               life_d = lifeBonus;
            end
         end
         LOST: begin
            life_d = lifeBonus;
            if (startOfFrame && timerTerminal) state_d = READY;
         end
         OVER:    life_d = '0;
         default: state_d = IDLE;
      endcase
      if (!start) begin
         state_d   = IDLE;
         life_d    = LIFE_INIT;
         launching = 1'b0;
      end
   end

   // A launch disarms the key until it has been seen released again.
   assign keyArmed_d = !launchKeyIsPressed ? 1'b1 : (keyArmed_q && !launching);

   assign timerLoad  = (state_d != state_q) && (state_d == LOST);
   assign timerClear = ((state_d != state_q) && (state_d != LOST)) || (state_q == IDLE);
   assign timerUp    = (state_q == READY) && startOfFrame;
   assign timerDown  = (state_q == LOST) && startOfFrame;

   frame_timer #(.W(CNT_W)) u_frame_timer (
      .clk       (clk),
      .resetN    (resetN),
      .clear     (timerClear),
      .load      (timerLoad),
      .loadValue (RESP_LOAD),
      .countUp   (timerUp),
      .countDown (timerDown),
      .termValue ((state_q == LOST) ? RESP_TERM : AUTO_TERM),
      .terminal  (timerTerminal)
   );

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= IDLE;
         life_q     <= LIFE_INIT;
         visible_q  <= 1'b0;
         plunger_q  <= 1'b0;
         launch_q   <= 1'b0;
         respawn_q  <= 1'b0;
         keyArmed_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         life_q     <= life_d;
         visible_q  <= (state_d == READY) || (state_d == PLAY);
         plunger_q  <= (state_d == READY);
         launch_q   <= launching;
         respawn_q  <= (state_d == LOST);
         keyArmed_q <= keyArmed_d;
      end
   end

   assign life          = life_q;
   assign ballVisible   = visible_q;
   assign ballOnPlunger = plunger_q;
   assign launchPulse   = launch_q;
   assign respawnActive = respawn_q;

endmodule
